// File: rtl/counter_driver_if.sv
// counter_driver_if: target handshake plus the command/status wires between
// counter_driver and a 3-bit up/down counter. The driver uses the slave view;
// whoever supplies targets and models the counter uses the master view.
interface counter_driver_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] Target_i;
  logic             TargetValid_i;
  logic             TargetReady_o;
  logic [WIDTH-1:0] Status_i;
  logic             Up_o;
  logic             Down_o;
  logic             Busy_o;
  logic             Done_o;
  logic             Error_o;

  modport slave (
    input  Target_i, TargetValid_i, Status_i,
    output TargetReady_o, Up_o, Down_o, Busy_o, Done_o, Error_o
  );

  modport master (
    output Target_i, TargetValid_i, Status_i,
    input  TargetReady_o, Up_o, Down_o, Busy_o, Done_o, Error_o
  );
endinterface

// File: rtl/counter_driver.sv
// counter_driver: walks a saturating up/down counter to a requested value by
// issuing single-cycle Up/Down pulses, one step per COMPARE/PULSE/SETTLE(/GAP)
// round, and reports completion (Done) or a counter that refused to move (Error).
// Optional feature: define COUNTER_DRIVER_ABORT_EN to add the Abort_i input,
// which ends a move early with Done and no Error.
module counter_driver #(
  parameter int WIDTH    = 3,
  parameter int MAX_VAL  = 7,
  parameter int STEP_GAP = 0
) (
  input  logic            Clock_i,
  input  logic            Reset_n_i,
`ifdef COUNTER_DRIVER_ABORT_EN
  input  logic            Abort_i,
`endif
  counter_driver_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    PULSE,
    SETTLE,
    GAP,
    DONE
  } state_t;

  localparam logic [WIDTH:0]   MAX_EXT   = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_CLAMP = WIDTH'(MAX_VAL);
  localparam logic [3:0]       GAP_LAST  = (STEP_GAP > 0) ? 4'(STEP_GAP - 1) : 4'd0;

  state_t           state_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] target_d;
  logic [WIDTH-1:0] snap_q;
  logic [3:0]       gapCnt_q;
  logic             ready_q;
  logic             up_q;
  logic             down_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic             abort;

`ifdef COUNTER_DRIVER_ABORT_EN
  assign abort = Abort_i;
`else
  assign abort = 1'b0;
`endif

  // Clamp an incoming target to the highest value the counter may legally hold
  always_comb begin
    target_d = bus.Target_i;
    if ({1'b0, bus.Target_i} > MAX_EXT) begin
      target_d = MAX_CLAMP;
    end
  end

  // Move sequencer: every output is a register updated alongside the state
  always_ff @(posedge Clock_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q  <= IDLE;
      target_q <= '0;
      snap_q   <= '0;
      gapCnt_q <= '0;
      ready_q  <= 1'b1;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.TargetValid_i && ready_q) begin
            target_q <= target_d;
            error_q  <= 1'b0;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= COMPARE;
          end
        end
        COMPARE: begin
          snap_q <= bus.Status_i;
          if (abort || (bus.Status_i == target_q)) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (bus.Status_i < target_q) begin
            up_q    <= 1'b1;
            state_q <= PULSE;
          end else begin
            down_q  <= 1'b1;
            state_q <= PULSE;
          end
        end
        PULSE: begin
          if (abort) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (bus.Status_i == snap_q) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (STEP_GAP > 0) begin
            gapCnt_q <= GAP_LAST;
            state_q  <= GAP;
          end else begin
            state_q <= COMPARE;
          end
        end
        GAP: begin
          if (abort) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (gapCnt_q == 4'd0) begin
            state_q <= COMPARE;
          end else begin
            gapCnt_q <= gapCnt_q - 4'd1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.TargetReady_o = ready_q;
  assign bus.Up_o          = up_q;
  assign bus.Down_o        = down_q;
  assign bus.Busy_o        = busy_q;
  assign bus.Done_o        = done_q;
  assign bus.Error_o       = error_q;

endmodule

// File: tb/tb_counter_driver.sv
// tb_counter_driver: two drivers (STEP_GAP=0/MAX_VAL=7 and STEP_GAP=2/MAX_VAL=5)
// each steering its own behavioural 3-bit saturating counter. Moves come from
// a constant table and from random draws scored against a move-level model.
module tb_counter_driver;

  localparam int GAP_A = 0;
  localparam int GAP_B = 2;
  localparam int MAX_A = 7;
  localparam int MAX_B = 5;

  typedef struct {
    bit sel;
    int start;
    int tgt;
    bit hold;
    int expUp;
    int expDown;
    int expLat;
    int expErr;
    int expFinal;
  } vec_t;

  logic       clock;
  logic       resetN;
  logic [2:0] tgtSig;
  logic       validSig;
  logic       selB;
  logic       abortSig;
  logic       presetEn;
  logic       presetSel;
  logic [2:0] presetVal;
  logic [1:0] holdCnt;
  logic [2:0] cnt [2];
  logic [1:0] upV;
  logic [1:0] downV;
  logic       mUp, mDown, mBusy, mDone, mErr, mReady;

  int nChecks = 0;
  int nErrors = 0;

  counter_driver_if #(.WIDTH(3)) busA ();
  counter_driver_if #(.WIDTH(3)) busB ();

  counter_driver #(.WIDTH(3), .MAX_VAL(MAX_A), .STEP_GAP(GAP_A)) dutA (
    .Clock_i   (clock),
    .Reset_n_i (resetN),
`ifdef COUNTER_DRIVER_ABORT_EN
    .Abort_i   (abortSig),
`endif
    .bus       (busA)
  );

  counter_driver #(.WIDTH(3), .MAX_VAL(MAX_B), .STEP_GAP(GAP_B)) dutB (
    .Clock_i   (clock),
    .Reset_n_i (resetN),
`ifdef COUNTER_DRIVER_ABORT_EN
    .Abort_i   (abortSig),
`endif
    .bus       (busB)
  );

  assign busA.Target_i      = tgtSig;
  assign busB.Target_i      = tgtSig;
  assign busA.TargetValid_i = validSig && !selB;
  assign busB.TargetValid_i = validSig && selB;
  assign busA.Status_i      = cnt[0];
  assign busB.Status_i      = cnt[1];
  assign upV                = {busB.Up_o, busA.Up_o};
  assign downV              = {busB.Down_o, busA.Down_o};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Route the selected driver's outputs to the checking signals
  always_comb begin
    if (selB) begin
      mUp = busB.Up_o; mDown = busB.Down_o; mBusy = busB.Busy_o;
      mDone = busB.Done_o; mErr = busB.Error_o; mReady = busB.TargetReady_o;
    end else begin
      mUp = busA.Up_o; mDown = busA.Down_o; mBusy = busA.Busy_o;
      mDone = busA.Done_o; mErr = busA.Error_o; mReady = busA.TargetReady_o;
    end
  end

  // Saturating counters; hold pins a counter at 0 like a counter kept in reset
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (presetEn && (int'(presetSel) == k)) cnt[k] <= presetVal;
      else if (holdCnt[k]) cnt[k] <= 3'd0;
      else if (upV[k] && cnt[k] != 3'd7) cnt[k] <= cnt[k] + 3'd1;
      else if (downV[k] && cnt[k] != 3'd0) cnt[k] <= cnt[k] - 3'd1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Move-level reference: step count is the distance to the clamped target
  function automatic vec_t refModel(input bit s, input int start, input int tgt, input bit hld);
    vec_t v;
    int maxV, gap, t, n;
    maxV = s ? MAX_B : MAX_A;
    gap  = s ? GAP_B : GAP_A;
    t    = (tgt > maxV) ? maxV : tgt;
    v.sel = s; v.start = hld ? 0 : start; v.tgt = tgt; v.hold = hld;
    if (hld && t != 0) begin
      v.expUp = 1; v.expDown = 0; v.expLat = 4; v.expErr = 1; v.expFinal = 0;
    end else begin
      n = (t > v.start) ? t - v.start : v.start - t;
      v.expUp    = (t > v.start) ? n : 0;
      v.expDown  = (t < v.start) ? n : 0;
      v.expLat   = 2 + n * (3 + gap);
      v.expErr   = 0;
      v.expFinal = t;
    end
    return v;
  endfunction

  task automatic presetCounter(input bit s, input int val, input bit hld);
    @(negedge clock);
    presetEn = 1'b1; presetSel = s; presetVal = 3'(val); holdCnt[s] = hld; selB = s;
    @(negedge clock);
    presetEn = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int gap, doneCyc, nUp, nDown, nPulse, busyCnt, spacingBad, overlap, readyBad;
    int errAtDone, errAtStart;
    gap = v.sel ? GAP_B : GAP_A;
    doneCyc = 0; nUp = 0; nDown = 0; nPulse = 0; busyCnt = 0; spacingBad = 0;
    overlap = 0; readyBad = 0; errAtDone = -1; errAtStart = -1;
    presetCounter(v.sel, v.start, v.hold);
    checkOutput("readyBeforeAccept", int'(mReady), 1);
    tgtSig = 3'(v.tgt); validSig = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      validSig = 1'b0;
      if (c == 1) errAtStart = int'(mErr);
      if (mUp && mDown) overlap++;
      if (mReady && mBusy) readyBad++;
      if (mBusy) busyCnt++;
      if (mUp || mDown) begin
        if (c != 2 + nPulse * (3 + gap)) spacingBad++;
        nPulse++;
        if (mUp) nUp++;
        if (mDown) nDown++;
      end
      if (mDone) begin
        doneCyc = c; errAtDone = int'(mErr);
        break;
      end
    end
    checkOutput("doneLatency", doneCyc, v.expLat);
    checkOutput("upPulses", nUp, v.expUp);
    checkOutput("downPulses", nDown, v.expDown);
    checkOutput("errorAtDone", errAtDone, v.expErr);
    checkOutput("errorClearedOnAccept", errAtStart, 0);
    checkOutput("busyCycles", busyCnt, v.expLat);
    checkOutput("pulseSpacing", spacingBad, 0);
    checkOutput("cmdOverlap", overlap, 0);
    checkOutput("readyWhileBusy", readyBad, 0);
    @(negedge clock);
    checkOutput("idleBusy", int'(mBusy), 0);
    checkOutput("idleReady", int'(mReady), 1);
    checkOutput("errorHeld", int'(mErr), v.expErr);
    checkOutput("finalStatus", int'(cnt[v.sel]), v.expFinal);
    holdCnt[v.sel] = 1'b0;
  endtask

  // Slow driver with TargetValid held high: the repeat request waits for Done
  task automatic runGapSequence();
    int firstDone, secondDone, readyBad, readyAfter, busyAfter, p0, p1;
    int pulseCyc[$];
    firstDone = 0; secondDone = 0; readyBad = 0; readyAfter = -1; busyAfter = -1;
    presetCounter(1'b1, 0, 1'b0);
    tgtSig = 3'd2; validSig = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (mReady && mBusy) readyBad++;
      if (mUp) pulseCyc.push_back(c);
      if (firstDone != 0 && c == firstDone + 1) readyAfter = int'(mReady);
      if (firstDone != 0 && c == firstDone + 2) busyAfter = int'(mBusy);
      if (mDone) begin
        if (firstDone == 0) firstDone = c;
        else begin
          secondDone = c; validSig = 1'b0;
          break;
        end
      end
    end
    validSig = 1'b0;
    p0 = (pulseCyc.size() > 0) ? pulseCyc[0] : -1;
    p1 = (pulseCyc.size() > 1) ? pulseCyc[1] : -1;
    checkOutput("gapPulseCount", pulseCyc.size(), 2);
    checkOutput("gapPulse0", p0, 2);
    checkOutput("gapPulse1", p1, 7);
    checkOutput("gapFirstDone", firstDone, 12);
    checkOutput("gapReadyAfterDone", readyAfter, 1);
    checkOutput("gapReaccepted", busyAfter, 1);
    checkOutput("gapSecondDone", secondDone, 15);
    checkOutput("gapReadyWhileBusy", readyBad, 0);
    @(negedge clock);
    checkOutput("gapFinalStatus", int'(cnt[1]), 2);
  endtask

  // Asynchronous reset landing in the middle of an Up pulse
  task automatic runResetSequence();
    int found, doneSeen;
    found = 0; doneSeen = 0;
    presetCounter(1'b0, 0, 1'b0);
    tgtSig = 3'd5; validSig = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      validSig = 1'b0;
      if (mUp) begin
        found = 1;
        break;
      end
    end
    checkOutput("upSeenBeforeReset", found, 1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("rstMidUp", int'(mUp), 0);
    checkOutput("rstMidBusy", int'(mBusy), 0);
    checkOutput("rstMidReady", int'(mReady), 1);
    checkOutput("rstMidDone", int'(mDone), 0);
    @(negedge clock);
    resetN = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (mDone) doneSeen++;
    end
    checkOutput("rstNoDone", doneSeen, 0);
    checkOutput("rstIdleBusy", int'(mBusy), 0);
    checkOutput("rstIdleReady", int'(mReady), 1);
  endtask

`ifdef COUNTER_DRIVER_ABORT_EN
  // Abort raised in the COMPARE that follows the second step's SETTLE
  task automatic runAbortSequence();
    int doneCyc, errAtDone;
    doneCyc = 0; errAtDone = -1;
    presetCounter(1'b0, 0, 1'b0);
    tgtSig = 3'd7; validSig = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      validSig = 1'b0;
      abortSig = (c == 7);
      if (mDone) begin
        doneCyc = c; errAtDone = int'(mErr);
        break;
      end
    end
    abortSig = 1'b0;
    checkOutput("abortDoneCycle", doneCyc, 8);
    checkOutput("abortError", errAtDone, 0);
    @(negedge clock);
    checkOutput("abortStatus", int'(cnt[0]), 2);
    checkOutput("abortIdleBusy", int'(mBusy), 0);
  endtask
`endif

  vec_t vecs[9];
  vec_t rv;

  initial begin
    vecs[0] = '{1'b0, 0, 5, 1'b0, 5, 0, 17, 0, 5};
    vecs[1] = '{1'b0, 6, 2, 1'b0, 0, 4, 14, 0, 2};
    vecs[2] = '{1'b0, 3, 3, 1'b0, 0, 0, 2, 0, 3};
    vecs[3] = '{1'b0, 0, 4, 1'b1, 1, 0, 4, 1, 0};
    vecs[4] = '{1'b0, 2, 2, 1'b0, 0, 0, 2, 0, 2};
    vecs[5] = '{1'b0, 7, 0, 1'b0, 0, 7, 23, 0, 0};
    vecs[6] = '{1'b1, 2, 7, 1'b0, 3, 0, 17, 0, 5};
    vecs[7] = '{1'b1, 5, 1, 1'b0, 0, 4, 22, 0, 1};
    vecs[8] = '{1'b1, 0, 3, 1'b1, 1, 0, 4, 1, 0};

    resetN = 1'b0; validSig = 1'b0; tgtSig = 3'd0; selB = 1'b0; abortSig = 1'b0;
    presetEn = 1'b0; presetSel = 1'b0; presetVal = 3'd0; holdCnt = 2'b00;
    repeat (3) @(negedge clock);
    checkOutput("rstReady", int'(mReady), 1);
    checkOutput("rstBusy", int'(mBusy), 0);
    checkOutput("rstUp", int'(mUp), 0);
    checkOutput("rstDown", int'(mDown), 0);
    checkOutput("rstDone", int'(mDone), 0);
    checkOutput("rstError", int'(mErr), 0);
    resetN = 1'b1;
    @(negedge clock);

    $display("[TB] table vectors");
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    $display("[TB] random moves");
    for (int i = 0; i < 24; i++) begin
      rv = refModel(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0));
      applyStimulus(rv);
    end

    $display("[TB] held-valid sequence");
    runGapSequence();
    $display("[TB] reset during pulse");
    runResetSequence();
`ifdef COUNTER_DRIVER_ABORT_EN
    $display("[TB] abort sequence");
    runAbortSequence();
`endif

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
